// File: rtl/detector_pulse_gen.sv
// detector_pulse_gen: multi-channel burst pulse generator for detector stimulus.
// Each channel runs IDLE -> HIGH -> LOW -> HIGH ... until its burst count is reached.
// Optional macro PULSE_GEN_JITTER_EN adds a shared 16-bit LFSR that stretches
// every LOW phase by lfsr[3:0] cycles. The port list is the same in both builds.
// Ports:
//   clk, reset      - single clock, synchronous active-high reset
//   enable          - global run enable; low forces every channel to IDLE
//   cfg_wr/cfg_chan - one-cycle write of period/width/count into one channel
//   cfg_period      - pulse period in cycles
//   cfg_width       - high time in cycles
//   cfg_count       - pulses per burst, 0 = continuous
//   pulses          - registered pulse outputs, one per channel
//   busy            - channel is in HIGH or LOW
//   done            - one-cycle strobe when a burst completes
module detector_pulse_gen #(
  parameter int unsigned CHANNELS = 4,
  parameter int unsigned CHAN_W   = 2,
  parameter int unsigned PERIOD_W = 16,
  parameter int unsigned COUNT_W  = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic                enable,
  input  logic                cfg_wr,
  input  logic [CHAN_W-1:0]   cfg_chan,
  input  logic [PERIOD_W-1:0] cfg_period,
  input  logic [PERIOD_W-1:0] cfg_width,
  input  logic [COUNT_W-1:0]  cfg_count,
  output logic [CHANNELS-1:0] pulses,
  output logic [CHANNELS-1:0] busy,
  output logic [CHANNELS-1:0] done
);

  // One extra bit so P-W-1 plus up to 15 jitter cycles never overflows.
  localparam int unsigned TMR_W = PERIOD_W + 1;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_HIGH = 2'd1,
    ST_LOW  = 2'd2
  } state_t;

`ifdef PULSE_GEN_JITTER_EN
  // Shared Galois LFSR, x^16+x^14+x^13+x^11+1, free-running.
  logic [15:0] lfsr_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      lfsr_q <= 16'hACE1;
    end else begin
      lfsr_q <= {1'b0, lfsr_q[15:1]} ^ (lfsr_q[0] ? 16'hB400 : 16'h0000);
    end
  end
`endif

  for (genvar c = 0; c < CHANNELS; c++) begin : g_ch
    state_t              state_q, state_d;
    logic [TMR_W-1:0]    timer_q, timer_d;
    logic [COUNT_W-1:0]  cnt_q, cnt_d, cnt_inc;
    logic                armed_q, armed_d;
    logic [PERIOD_W-1:0] period_q, period_d;
    logic [PERIOD_W-1:0] width_q, width_d;
    logic [COUNT_W-1:0]  count_q, count_d;
    logic                done_d;
    logic                pulse_q, busy_q, done_q;
    logic                wr_hit;
    logic [TMR_W-1:0]    hi_load, lo_base, lo_load;

    // Out-of-range channel numbers never match any instance.
    assign wr_hit  = cfg_wr && (cfg_chan == CHAN_W'(c));
    assign cnt_inc = cnt_q + COUNT_W'(1);

    // Timers count down to zero, so load length-1; W=0 behaves as W=1, P<=W gives LOW=1.
    assign hi_load = (width_q == '0) ? '0 : TMR_W'(width_q) - TMR_W'(1);
    assign lo_base = (period_q > width_q)
                   ? TMR_W'(period_q) - TMR_W'(width_q) - TMR_W'(1) : '0;
`ifdef PULSE_GEN_JITTER_EN
    assign lo_load = lo_base + TMR_W'(lfsr_q[3:0]);
`else
    assign lo_load = lo_base;
`endif

    // Next-state: config write beats enable-low beats normal sequencing.
    always_comb begin
      state_d  = state_q;
      timer_d  = timer_q;
      cnt_d    = cnt_q;
      armed_d  = armed_q;
      period_d = period_q;
      width_d  = width_q;
      count_d  = count_q;
      done_d   = 1'b0;
      if (wr_hit) begin
        period_d = cfg_period;
        width_d  = cfg_width;
        count_d  = cfg_count;
        cnt_d    = '0;
        armed_d  = 1'b1;
        state_d  = ST_IDLE;
      end else if (!enable) begin
        state_d = ST_IDLE;
      end else begin
        unique case (state_q)
          ST_IDLE: begin
            if (armed_q) begin
              state_d = ST_HIGH;
              timer_d = hi_load;
              cnt_d   = '0;
            end
          end
          ST_HIGH: begin
            if (timer_q == '0) begin
              state_d = ST_LOW;
              timer_d = lo_load;
            end else begin
              timer_d = timer_q - TMR_W'(1);
            end
          end
          ST_LOW: begin
            if (timer_q == '0) begin
              cnt_d = cnt_inc;
              if ((count_q != '0) && (cnt_inc == count_q)) begin
                state_d = ST_IDLE;
                armed_d = 1'b0;
                done_d  = 1'b1;
              end else begin
                state_d = ST_HIGH;
                timer_d = hi_load;
              end
            end else begin
              timer_d = timer_q - TMR_W'(1);
            end
          end
          default: state_d = ST_IDLE;
        endcase
      end
    end

    // State and registered outputs, decoded from the next state.
    always_ff @(posedge clk) begin
      if (reset) begin
        state_q  <= ST_IDLE;
        timer_q  <= '0;
        cnt_q    <= '0;
        armed_q  <= 1'b0;
        period_q <= PERIOD_W'(16);
        width_q  <= PERIOD_W'(2);
        count_q  <= '0;
        pulse_q  <= 1'b0;
        busy_q   <= 1'b0;
        done_q   <= 1'b0;
      end else begin
        state_q  <= state_d;
        timer_q  <= timer_d;
        cnt_q    <= cnt_d;
        armed_q  <= armed_d;
        period_q <= period_d;
        width_q  <= width_d;
        count_q  <= count_d;
        pulse_q  <= (state_d == ST_HIGH);
        busy_q   <= (state_d != ST_IDLE);
        done_q   <= done_d;
      end
    end

    assign pulses[c] = pulse_q;
    assign busy[c]   = busy_q;
    assign done[c]   = done_q;
  end

endmodule

// File: tb/tb_detector_pulse_gen.sv
// tb_detector_pulse_gen: directed scenarios plus random traffic for
// detector_pulse_gen, checked every cycle against a phase/length reference model.
module tb_detector_pulse_gen;

  localparam int unsigned NCH      = 3;
  localparam int unsigned CHAN_W   = 2;
  localparam int unsigned PERIOD_W = 16;
  localparam int unsigned COUNT_W  = 16;

  logic                clk = 1'b0;
  logic                reset = 1'b1;
  logic                enable = 1'b0;
  logic                cfg_wr = 1'b0;
  logic [CHAN_W-1:0]   cfg_chan = '0;
  logic [PERIOD_W-1:0] cfg_period = '0;
  logic [PERIOD_W-1:0] cfg_width = '0;
  logic [COUNT_W-1:0]  cfg_count = '0;
  logic [NCH-1:0]      pulses, busy, done;

  detector_pulse_gen #(
    .CHANNELS(NCH), .CHAN_W(CHAN_W), .PERIOD_W(PERIOD_W), .COUNT_W(COUNT_W)
  ) dut (
    .clk(clk), .reset(reset), .enable(enable), .cfg_wr(cfg_wr),
    .cfg_chan(cfg_chan), .cfg_period(cfg_period), .cfg_width(cfg_width),
    .cfg_count(cfg_count), .pulses(pulses), .busy(busy), .done(done)
  );

  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  // Reference model: each channel is either stopped or in a phase with a
  // number of cycles left; lengths are computed straight from P, W and jitter.
  int          m_p[NCH], m_w[NCH], m_n[NCH];
  bit          m_armed[NCH], m_run[NCH], m_high[NCH];
  int          m_left[NCH], m_completed[NCH];
  logic [15:0] m_lfsr = 16'hACE1;
  logic [NCH-1:0] exp_pulses = '0, exp_busy = '0, exp_done = '0;

  function automatic int high_len(int w);
    return (w < 1) ? 1 : w;
  endfunction

  function automatic int low_len(int p, int w, logic [15:0] lf);
    int base;
    base = (p > w) ? p - w : 1;
`ifdef PULSE_GEN_JITTER_EN
    base = base + int'(lf[3:0]);
`endif
    return base;
  endfunction

  always @(posedge clk) begin
    if (reset) begin
      for (int c = 0; c < NCH; c++) begin
        m_p[c] = 16; m_w[c] = 2; m_n[c] = 0;
        m_armed[c] = 0; m_run[c] = 0; m_high[c] = 0;
        m_left[c] = 0; m_completed[c] = 0;
      end
      m_lfsr = 16'hACE1;
      exp_done = '0;
    end else begin
      for (int c = 0; c < NCH; c++) begin
        exp_done[c] = 1'b0;
        if (cfg_wr && int'(cfg_chan) == c) begin
          m_p[c] = int'(cfg_period); m_w[c] = int'(cfg_width); m_n[c] = int'(cfg_count);
          m_armed[c] = 1; m_run[c] = 0; m_completed[c] = 0;
        end else if (!enable) begin
          m_run[c] = 0;
        end else if (!m_run[c]) begin
          if (m_armed[c]) begin
            m_run[c] = 1; m_high[c] = 1; m_left[c] = high_len(m_w[c]); m_completed[c] = 0;
          end
        end else begin
          m_left[c]--;
          if (m_left[c] == 0) begin
            if (m_high[c]) begin
              m_high[c] = 0;
              m_left[c] = low_len(m_p[c], m_w[c], m_lfsr);
            end else begin
              m_completed[c] = (m_completed[c] + 1) % 65536;
              if (m_n[c] != 0 && m_completed[c] == m_n[c]) begin
                m_run[c] = 0; m_armed[c] = 0; exp_done[c] = 1'b1;
              end else begin
                m_high[c] = 1; m_left[c] = high_len(m_w[c]);
              end
            end
          end
        end
      end
      m_lfsr = (m_lfsr >> 1) ^ (m_lfsr[0] ? 16'hB400 : 16'h0000);
    end
    for (int c = 0; c < NCH; c++) begin
      exp_pulses[c] = m_run[c] && m_high[c];
      exp_busy[c]   = m_run[c];
    end
  end

  // Per-channel activity statistics gathered at each sample point.
  int rise_cnt[NCH], high_cnt[NCH], done_cnt[NCH];
  logic [NCH-1:0] prev_p = '0;
  bit jit_mon = 0;
  bit low_valid = 0;
  int seg = 0;

  task automatic clear_stats();
    for (int c = 0; c < NCH; c++) begin
      rise_cnt[c] = 0; high_cnt[c] = 0; done_cnt[c] = 0;
    end
  endtask

  task automatic step(input int n);
    for (int k = 0; k < n; k++) begin
      @(negedge clk);
      check("pulses", 32'(pulses), 32'(exp_pulses));
      check("busy", 32'(busy), 32'(exp_busy));
      check("done", 32'(done), 32'(exp_done));
      for (int c = 0; c < NCH; c++) begin
        if (pulses[c] && !prev_p[c]) rise_cnt[c]++;
        if (pulses[c]) high_cnt[c]++;
        if (done[c]) done_cnt[c]++;
      end
      if (jit_mon) begin
        if (pulses[0] == prev_p[0]) begin
          seg++;
        end else begin
          if (prev_p[0]) begin
            check("jit_high_len", 32'(seg), 32'd3);
            low_valid = 1;
          end else if (low_valid) begin
            check("jit_low_in_range", 32'(seg >= 7 && seg <= 22), 32'd1);
          end
          seg = 1;
        end
      end
      prev_p = pulses;
    end
  endtask

  task automatic cfg(input int ch, input int p, input int w, input int n);
    cfg_wr = 1'b1;
    cfg_chan = CHAN_W'(ch);
    cfg_period = PERIOD_W'(p);
    cfg_width = PERIOD_W'(w);
    cfg_count = COUNT_W'(n);
    step(1);
    cfg_wr = 1'b0;
  endtask

  initial begin
    bit found;
    clear_stats();

    // Reset state and reset configuration values.
    step(2);
    check("rst_pulses", 32'(pulses), 32'd0);
    check("rst_busy", 32'(busy), 32'd0);
    reset = 1'b0;
    step(1);
    check("rst_period", 32'(dut.g_ch[0].period_q), 32'd16);
    check("rst_width", 32'(dut.g_ch[0].width_q), 32'd2);
    check("rst_count", 32'(dut.g_ch[0].count_q), 32'd0);

    // Finite burst on channel 0.
    enable = 1'b1;
    clear_stats();
    cfg(0, 10, 3, 4);
    step(120);
    check("burst_pulses", 32'(rise_cnt[0]), 32'd4);
    check("burst_high_cycles", 32'(high_cnt[0]), 32'd12);
    check("burst_done", 32'(done_cnt[0]), 32'd1);
    check("burst_busy_end", 32'(busy[0]), 32'd0);

    // Degenerate fields: W>P and W=0.
    clear_stats();
    cfg(1, 2, 5, 2);
    cfg(2, 6, 0, 3);
    step(80);
    check("wgtp_pulses", 32'(rise_cnt[1]), 32'd2);
    check("wgtp_high_cycles", 32'(high_cnt[1]), 32'd10);
    check("w0_pulses", 32'(rise_cnt[2]), 32'd3);
    check("w0_high_cycles", 32'(high_cnt[2]), 32'd3);

    // Continuous run, enable drop, restart, then rewrite mid-HIGH.
    clear_stats();
    cfg(0, 8, 2, 0);
    step(20);
    enable = 1'b0;
    step(1);
    check("en_low_pulse", 32'(pulses[0]), 32'd0);
    step(4);
    enable = 1'b1;
    step(2);
    check("en_restart_high", 32'(pulses[0]), 32'd1);
    step(9);
    found = 0;
    for (int i = 0; i < 50 && !found; i++) begin
      if (pulses[0]) found = 1; else step(1);
    end
    check("wait_high", 32'(found), 32'd1);
    cfg(0, 8, 2, 0);
    check("abort_pulse_drop", 32'(pulses[0]), 32'd0);
    check("abort_no_done", 32'(done[0]), 32'd0);

    // Write coinciding with the final LOW cycle wins over completion.
    cfg(0, 4, 1, 1);
    found = 0;
    for (int i = 0; i < 60 && !found; i++) begin
      step(1);
      if (m_run[0] && !m_high[0] && m_left[0] == 1 && m_completed[0] + 1 == m_n[0]) found = 1;
    end
    check("wait_final_low", 32'(found), 32'd1);
    cfg(0, 4, 1, 1);
    check("wr_wins_done", 32'(done[0]), 32'd0);
    check("wr_wins_busy", 32'(busy[0]), 32'd0);
    step(30);

    // Reset mid-burst.
    cfg(1, 10, 3, 0);
    step(5);
    reset = 1'b1;
    step(1);
    check("midrst_pulses", 32'(pulses), 32'd0);
    check("midrst_busy", 32'(busy), 32'd0);
    check("midrst_done", 32'(done), 32'd0);
    check("midrst_period", 32'(dut.g_ch[1].period_q), 32'd16);
    check("midrst_width", 32'(dut.g_ch[1].width_q), 32'd2);
    reset = 1'b0;

    // Out-of-range channel write has no effect.
    cfg(3, 5, 1, 1);
    step(10);
    check("oor_busy", 32'(busy), 32'd0);
    check("oor_period0", 32'(dut.g_ch[0].period_q), 32'd16);

`ifdef PULSE_GEN_JITTER_EN
    // Jitter: high time fixed, low time stretched by LFSR.
    clear_stats();
    jit_mon = 1; low_valid = 0; seg = 0;
    cfg(0, 10, 3, 8);
    step(260);
    jit_mon = 0;
    check("jit_pulses", 32'(rise_cnt[0]), 32'd8);
    check("jit_done", 32'(done_cnt[0]), 32'd1);
`endif

    // Random traffic against the model.
    for (int i = 0; i < 3000; i++) begin
      enable = ($urandom_range(0, 19) != 0);
      if ($urandom_range(0, 14) == 0) begin
        cfg_wr = 1'b1;
        cfg_chan = CHAN_W'($urandom_range(0, 3));
        cfg_period = PERIOD_W'($urandom_range(0, 12));
        cfg_width = PERIOD_W'($urandom_range(0, 6));
        cfg_count = COUNT_W'($urandom_range(0, 4));
      end else begin
        cfg_wr = 1'b0;
      end
      step(1);
    end
    cfg_wr = 1'b0;
    step(2);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
